fg_sweep_ctrl: RTL and testbench

Frequency-sweep scheduler for the DDS function generator. It owns the phase-increment word that feeds the phase accumulator. It steps that word from a start value to a stop value, one step per programmed number of sample-enable strobes. It supports single, continuous (sawtooth) and up-down (triangle) sweeps. It sits between the front-panel/config registers and the phase accumulator, and is paced by the sampling controller's Enable strobe.

---
 rtl/fg_sweep_ctrl.sv | 169 ++++++++++++++++
 tb/tb_fg_sweep_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fg_sweep_ctrl.sv
// Frequency-sweep scheduler: steps the DDS phase increment from a start to a
// stop value, one step per programmed number of Enable strobes, with single,
// continuous (sawtooth) and up-down (triangle) sweep shapes.
module fg_sweep_ctrl #(
  parameter int unsigned W  = 32,
  parameter int unsigned DW = 16
) (
  input  logic          Fg_clk,
  input  logic          Reset,
  input  logic          Enable,
  input  logic          Start,
  input  logic          Abort,
  input  logic [1:0]    SweepMode,
  input  logic [W-1:0]  StartInc,
  input  logic [W-1:0]  StopInc,
  input  logic [W-1:0]  StepInc,
  input  logic [DW-1:0] Dwell,
  output logic [W-1:0]  PhaseInc,
  output logic          IncValid,
  output logic          Busy,
  output logic          Done,
  output logic          CfgErr
);

  typedef enum logic [1:0] {StIdle, StDwell, StStep, StDone} state_e;

  localparam logic [1:0] ModeCont   = 2'd1;
  localparam logic [1:0] ModeUpDown = 2'd2;

  state_e        state_q;
  logic [W-1:0]  phase_q, start_q, stop_q, step_q;
  logic [DW-1:0] dwell_q, cnt_q;
  logic [1:0]    mode_q;
  logic          dir_down_q;
  logic          inc_valid_q, busy_q, done_q, cfg_err_q;

  logic [W:0]    up_sum, dn_diff;
  logic [W-1:0]  up_val, dn_val, step_phase_d;
  logic          step_dir_down_d, step_done_d;
  logic [DW-1:0] cnt_inc, dwell_eff;
  logic          cfg_bad;

  // Next phase increment for the STEP cycle; W+1-bit arithmetic catches
  // carry/borrow so the result is clamped into [start, stop] without wrapping.
  always_comb begin
    up_sum   = {1'b0, phase_q} + {1'b0, step_q};
    dn_diff  = {1'b0, phase_q} - {1'b0, step_q};
    up_val   = (up_sum >= {1'b0, stop_q}) ? stop_q : up_sum[W-1:0];
    dn_val   = (dn_diff[W] || (dn_diff[W-1:0] <= start_q)) ? start_q : dn_diff[W-1:0];

    step_phase_d    = phase_q;
    step_dir_down_d = dir_down_q;
    step_done_d     = 1'b0;
    if (!dir_down_q) begin
      if (phase_q == stop_q) begin
        // End of an upward run
        if (mode_q == ModeCont) begin
          step_phase_d = start_q;
        end else if (mode_q == ModeUpDown) begin
          step_dir_down_d = 1'b1;
          step_phase_d    = dn_val;
        end else begin
          step_done_d = 1'b1;
        end
      end else begin
        step_phase_d = up_val;
      end
    end else begin
      if (phase_q == start_q) begin
        // Bottom of a triangle: turn around and take the up step immediately
        step_dir_down_d = 1'b0;
        step_phase_d    = up_val;
      end else begin
        step_phase_d = dn_val;
      end
    end

    cnt_inc   = cnt_q + {{(DW-1){1'b0}}, 1'b1};
    dwell_eff = (dwell_q == '0) ? {{(DW-1){1'b0}}, 1'b1} : dwell_q;
    cfg_bad   = (StepInc == '0) || (StartInc > StopInc);
  end

  // Sweep FSM with registered outputs
  always_ff @(posedge Fg_clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      start_q     <= '0;
      stop_q      <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      mode_q      <= '0;
      cnt_q       <= '0;
      dir_down_q  <= 1'b0;
      inc_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      inc_valid_q <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      if (Abort && (state_q != StIdle)) begin
        // PhaseInc deliberately holds its last value
        state_q    <= StIdle;
        busy_q     <= 1'b0;
        cnt_q      <= '0;
        dir_down_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (Start && !Abort) begin
              if (cfg_bad) begin
                cfg_err_q <= 1'b1;
              end else begin
                start_q     <= StartInc;
                stop_q      <= StopInc;
                step_q      <= StepInc;
                dwell_q     <= Dwell;
                mode_q      <= SweepMode;
                phase_q     <= StartInc;
                inc_valid_q <= 1'b1;
                dir_down_q  <= 1'b0;
                cnt_q       <= '0;
                busy_q      <= 1'b1;
                state_q     <= StDwell;
              end
            end
          end
          StDwell: begin
            if (Enable) begin
              if (cnt_inc == dwell_eff) begin
                cnt_q   <= '0;
                state_q <= StStep;
              end else begin
                cnt_q <= cnt_inc;
              end
            end
          end
          StStep: begin
            if (step_done_d) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              phase_q     <= step_phase_d;
              inc_valid_q <= (step_phase_d != phase_q);
              dir_down_q  <= step_dir_down_d;
              state_q     <= StDwell;
            end
          end
          StDone: begin
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign PhaseInc = phase_q;
  assign IncValid = inc_valid_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign CfgErr   = cfg_err_q;

endmodule

// File: tb/tb_fg_sweep_ctrl.sv
// Bench for fg_sweep_ctrl: a sweep model driven by the same inputs is compared
// with the DUT every cycle, and directed scenarios pin literal sequences.
module tb_fg_sweep_ctrl;
  localparam int W  = 32;
  localparam int DW = 16;

  localparam int WIdle = 0;
  localparam int WWait = 1;
  localparam int WStep = 2;
  localparam int WFin  = 3;

  logic          Fg_clk = 1'b0;
  logic          Reset, Enable, Start, Abort;
  logic [1:0]    SweepMode;
  logic [W-1:0]  StartInc, StopInc, StepInc;
  logic [DW-1:0] Dwell;
  logic [W-1:0]  PhaseInc;
  logic          IncValid, Busy, Done, CfgErr;

  always #5 Fg_clk = ~Fg_clk;

  fg_sweep_ctrl #(.W(W), .DW(DW)) dut (
    .Fg_clk    (Fg_clk),
    .Reset     (Reset),
    .Enable    (Enable),
    .Start     (Start),
    .Abort     (Abort),
    .SweepMode (SweepMode),
    .StartInc  (StartInc),
    .StopInc   (StopInc),
    .StepInc   (StepInc),
    .Dwell     (Dwell),
    .PhaseInc  (PhaseInc),
    .IncValid  (IncValid),
    .Busy      (Busy),
    .Done      (Done),
    .CfgErr    (CfgErr)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint m_phase;
  bit     m_valid, m_busy, m_done, m_err;
  int     m_where;
  longint c_start, c_stop, c_step;
  int     c_dwell, c_left, c_mode;
  bit     c_down;
  longint m_seq[$];
  int     m_done_cnt = 0;

  function automatic longint up_rule(input longint p);
    longint s = p + c_step;
    return (s >= c_stop) ? c_stop : s;
  endfunction

  function automatic longint down_rule(input longint p);
    longint d = p - c_step;
    return (d <= c_start) ? c_start : d;
  endfunction

  task automatic model_edge();
    longint nxt;
    bit fin;
    if (Reset) begin
      m_phase = 0; m_valid = 0; m_busy = 0; m_done = 0; m_err = 0;
      m_where = WIdle; c_start = 0; c_stop = 0; c_step = 0; c_dwell = 0;
      c_left = 0; c_mode = 0; c_down = 0;
      return;
    end
    m_valid = 0; m_done = 0; m_err = 0;
    if (Abort && m_where != WIdle) begin
      m_where = WIdle; m_busy = 0; c_down = 0;
      return;
    end
    case (m_where)
      WIdle: begin
        if (Start && !Abort) begin
          if (StepInc == 0 || StartInc > StopInc) begin
            m_err = 1;
          end else begin
            c_start = StartInc; c_stop = StopInc; c_step = StepInc;
            c_dwell = (Dwell == 0) ? 1 : int'(Dwell);
            c_mode  = int'(SweepMode);
            c_down  = 0;
            m_phase = c_start; m_valid = 1; m_busy = 1;
            c_left  = c_dwell; m_where = WWait;
          end
        end
      end
      WWait: begin
        if (Enable) begin
          c_left--;
          if (c_left == 0) m_where = WStep;
        end
      end
      WStep: begin
        fin = 0;
        nxt = m_phase;
        if (!c_down) begin
          if (m_phase == c_stop) begin
            if (c_mode == 1) nxt = c_start;
            else if (c_mode == 2) begin c_down = 1; nxt = down_rule(m_phase); end
            else fin = 1;
          end else nxt = up_rule(m_phase);
        end else begin
          if (m_phase == c_start) begin c_down = 0; nxt = up_rule(m_phase); end
          else nxt = down_rule(m_phase);
        end
        if (fin) begin
          m_where = WFin; m_busy = 0; m_done = 1;
        end else begin
          m_valid = (nxt != m_phase);
          m_phase = nxt;
          c_left  = c_dwell;
          m_where = WWait;
        end
      end
      default: m_where = WIdle;
    endcase
  endtask

  initial begin
    forever begin
      @(posedge Fg_clk);
      model_edge();
      if (m_valid) m_seq.push_back(m_phase);
      if (m_done) m_done_cnt++;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit         m_on = 0;
  logic [W-1:0] d_seq[$];
  int         d_done_cnt = 0;

  initial begin
    forever begin
      @(negedge Fg_clk);
      if (m_on) begin
        check("PhaseInc", {32'b0, PhaseInc}, m_phase);
        check("IncValid", {63'b0, IncValid}, {63'b0, m_valid});
        check("Busy",     {63'b0, Busy},     {63'b0, m_busy});
        check("Done",     {63'b0, Done},     {63'b0, m_done});
        check("CfgErr",   {63'b0, CfgErr},   {63'b0, m_err});
        if (IncValid === 1'b1) d_seq.push_back(PhaseInc);
        if (Done === 1'b1) d_done_cnt++;
      end
    end
  end

  // ---------------- Enable generator ----------------
  int en_per = 0;
  int cyc_cnt = 0;
  initial begin
    Enable = 1'b0;
    forever begin
      @(negedge Fg_clk);
      cyc_cnt++;
      Enable = (en_per > 0) && (cyc_cnt % en_per == 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge Fg_clk);
  endtask

  task automatic go(input logic [W-1:0] s, input logic [W-1:0] e, input logic [W-1:0] st,
                    input logic [DW-1:0] dw, input logic [1:0] md);
    StartInc = s; StopInc = e; StepInc = st; Dwell = dw; SweepMode = md;
    m_seq.delete(); d_seq.delete(); m_done_cnt = 0; d_done_cnt = 0;
    Start = 1'b1;
    cyc(1);
    Start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (!m_done && k < budget) begin cyc(1); k++; end
    check({name, " done within budget"}, {63'b0, k < budget}, 64'd1);
  endtask

  task automatic wait_len(input string name, input int len, input int budget);
    int k = 0;
    while (m_seq.size() < len && k < budget) begin cyc(1); k++; end
    check({name, " length reached"}, {63'b0, k < budget}, 64'd1);
  endtask

  task automatic seq_check(input string name, input longint e[$]);
    check({name, " model len"}, {63'b0, m_seq.size() >= e.size()}, 64'd1);
    check({name, " dut len"},   {63'b0, d_seq.size() >= e.size()}, 64'd1);
    for (int i = 0; i < e.size(); i++) begin
      if (i < m_seq.size()) check($sformatf("%s model[%0d]", name, i), m_seq[i], e[i]);
      if (i < d_seq.size()) check($sformatf("%s dut[%0d]", name, i), {32'b0, d_seq[i]}, e[i]);
    end
  endtask

  task automatic do_abort();
    Abort = 1'b1;
    cyc(1);
    Abort = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    longint e[$];
    int k;
    Reset = 1'b1; Start = 1'b0; Abort = 1'b0; SweepMode = 2'd0;
    StartInc = '0; StopInc = '0; StepInc = '0; Dwell = '0;
    cyc(3);
    m_on = 1;
    check("reset PhaseInc", {32'b0, PhaseInc}, 64'd0);
    check("reset Busy", {63'b0, Busy}, 64'd0);
    Reset = 1'b0;
    cyc(2);

    // Single sweep
    en_per = 4;
    go(32'd100, 32'd130, 32'd10, 16'd2, 2'd0);
    check("single start IncValid", {63'b0, IncValid}, 64'd1);
    wait_done("single", 300);
    e = '{100, 110, 120, 130};
    seq_check("single seq", e);
    cyc(1);
    check("single Busy after", {63'b0, Busy}, 64'd0);
    check("single PhaseInc after", {32'b0, PhaseInc}, 64'd130);
    check("single done count", d_done_cnt, 64'd1);
    check("single model done count", m_done_cnt, 64'd1);
    cyc(2);

    // Clamp at the top of the range, no wrap
    en_per = 2;
    go(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1, 2'd0);
    wait_done("clamp", 100);
    e = '{64'hFFFF_FFF0, 64'hFFFF_FFFF};
    seq_check("clamp seq", e);
    cyc(1);
    check("clamp PhaseInc after", {32'b0, PhaseInc}, 64'hFFFF_FFFF);
    cyc(2);

    // Up-down triangle
    go(32'd0, 32'd30, 32'd10, 16'd1, 2'd2);
    wait_len("updown", 8, 200);
    e = '{0, 10, 20, 30, 20, 10, 0, 10};
    seq_check("updown seq", e);
    check("updown no Done", d_done_cnt, 64'd0);
    do_abort();
    cyc(2);

    // Continuous, Dwell=0
    en_per = 3;
    go(32'd5, 32'd15, 32'd5, 16'd0, 2'd1);
    wait_len("cont", 5, 200);
    e = '{5, 10, 15, 5, 10};
    seq_check("cont seq", e);
    do_abort();
    cyc(2);

    // Rejections
    en_per = 0;
    go(32'd10, 32'd20, 32'd0, 16'd1, 2'd0);
    check("step0 CfgErr", {63'b0, CfgErr}, 64'd1);
    check("step0 Busy", {63'b0, Busy}, 64'd0);
    cyc(1);
    check("step0 CfgErr one cycle", {63'b0, CfgErr}, 64'd0);
    go(32'd50, 32'd40, 32'd1, 16'd1, 2'd0);
    check("start>stop CfgErr", {63'b0, CfgErr}, 64'd1);
    cyc(2);

    // Abort with Start in IDLE: Abort wins
    StartInc = 32'd1; StopInc = 32'd9; StepInc = 32'd1; Dwell = 16'd1; SweepMode = 2'd0;
    Start = 1'b1; Abort = 1'b1;
    cyc(1);
    Start = 1'b0; Abort = 1'b0;
    check("abort+start Busy", {63'b0, Busy}, 64'd0);
    cyc(2);

    // Abort mid-dwell at 20, with an ignored Start while busy
    en_per = 2;
    go(32'd0, 32'd100, 32'd10, 16'd3, 2'd0);
    k = 0;
    while (!(m_valid && m_phase == 20) && k < 200) begin cyc(1); k++; end
    check("abort reach 20", {63'b0, k < 200}, 64'd1);
    StartInc = 32'd999; StopInc = 32'd2000; StepInc = 32'd7;
    Start = 1'b1;
    cyc(1);
    Start = 1'b0;
    check("busy Start ignored", {32'b0, PhaseInc}, 64'd20);
    do_abort();
    check("abort Busy", {63'b0, Busy}, 64'd0);
    check("abort PhaseInc", {32'b0, PhaseInc}, 64'd20);
    check("abort Done", {63'b0, Done}, 64'd0);
    cyc(10);
    check("abort no Done later", d_done_cnt, 64'd0);

    // Start==Stop continuous: only the initial load pulses IncValid
    go(32'd7, 32'd7, 32'd1, 16'd1, 2'd1);
    cyc(20);
    check("static cont dut pulses", d_seq.size(), 64'd1);
    check("static cont model pulses", m_seq.size(), 64'd1);
    check("static cont Busy", {63'b0, Busy}, 64'd1);
    do_abort();
    cyc(2);

    // Reset mid-sweep
    en_per = 1;
    go(32'd0, 32'd1000, 32'd1, 16'd1, 2'd1);
    cyc(10);
    Reset = 1'b1;
    cyc(1);
    check("midreset PhaseInc", {32'b0, PhaseInc}, 64'd0);
    check("midreset IncValid", {63'b0, IncValid}, 64'd0);
    check("midreset Busy", {63'b0, Busy}, 64'd0);
    check("midreset Done", {63'b0, Done}, 64'd0);
    check("midreset CfgErr", {63'b0, CfgErr}, 64'd0);
    Reset = 1'b0;
    en_per = 0;
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
